sifive_insight_tla_checker: RTL and testbench
=============================================

# sifive_insight_tla_checker

Passive protocol checker and beat tracker on the hart-0 data-port TileLink-UL A channel. It sits directly downstream of the A-channel bundle, observing the same ready/valid/payload signals without driving them. It also observes D-channel completions. It tracks multi-beat Put bursts, maintains per-source in-flight state, and raises sticky error flags plus optional request statistics for the Insight debug/trace fabric.

## Interface
- MAX_SIZE, 6, largest legal `a_size` (log2 bytes); 64 B gives 16 beats max.
- CNT_W, 16, width of the statistics counters.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- a_ready, a_valid  in  1 each  A-channel handshake; fire = a_valid & a_ready.
- a_opcode  in  3  A-channel opcode.
- a_param  in  3  A-channel param.
- a_size  in  4  A-channel size.
- a_source  in  1  A-channel source.
- a_address  in  32  A-channel address.
- a_mask  in  4  A-channel byte mask.
- a_data  in  32  A-channel data.
- a_corrupt  in  1  A-channel corrupt bit.
- d_done  in  1  last beat of a D response fired.
- d_source  in  1  source of that D response.
- err_clear  in  1  synchronous clear of the error state.
- err_sticky  out  8  one bit per error class, sticky.
- err_first  out  3  index of the first error latched since reset or clear.
- err_any  out  1  OR of err_sticky.
- beat_idx  out  4  index of the next expected beat within the current burst.
- in_burst  out  1  FSM is in BURST.
- outstanding  out  2  per-source in-flight bits.
- req_done  out  1  one-cycle pulse when the last A beat of a request fired.
- put_count, get_count  out  CNT_W each  saturating request counters.

## Operation
- Legal opcodes: PutFull=0, PutPartial=1, Get=4.
- Beats per request: 1 for Get or size≤2; 2^(size−2) for Put with size>2.
- FSM IDLE→BURST on a first-beat fire of a Put with more than one beat. Captures opcode, param, size, source and address, and sets beat_idx=1.
- In BURST, each fire increments beat_idx. The FSM returns to IDLE on the fire where beat_idx = beats−1, which also zeroes beat_idx.
- Single-beat requests stay in IDLE.
- outstanding[src] is set on a first-beat fire and cleared on d_done for d_source. If both hit the same source in the same cycle, the clear applies first, then the set, so the bit ends at 1 with no error.
- Error bits, checked on every fire unless stated otherwise:
  - [0] opcode illegal.
  - [1] param≠0.
  - [2] size>MAX_SIZE.
  - [3] address not aligned to min(2^size, 4) at first beat, or not aligned to 2^size for bursts.
  - [4] mask error. Expected mask is 4'hF for size≥2, otherwise the lanes addressed by address[1:0] and size. PutFull and Get must match it exactly; PutPartial must be a subset of it.
  - [5] in BURST, opcode, param, size, source or address differs from the captured values.
  - [6] stall violation, checked every cycle: the previous cycle had a_valid & !a_ready, and this cycle a_valid dropped or any payload bit (including data, mask, corrupt) changed.
  - [7] first-beat fire on a source whose outstanding bit is set (after the same-cycle clear), or d_done on a source that is not outstanding.
- err_first latches the lowest-numbered bit among the errors raised in the first cycle that sets any bit. It holds until err_clear.
- err_clear zeroes err_sticky and err_first. Errors detected in the same cycle as err_clear are still latched, because set wins.
- Errors never change FSM or beat tracking. A burst with errors still completes after its expected beat count.

## Timing
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- err_sticky, err_first and err_any update one cycle after the violating edge.
- req_done pulses in the cycle after the last-beat fire.
- beat_idx, in_burst and outstanding reflect fires and d_done from the previous edge.
- Counters update together with req_done and saturate at all-ones; they do not wrap.
- Reset asserted mid-burst immediately returns the FSM to IDLE and clears all state asynchronously. The first fire after reset is treated as a first beat.

## Configuration
- SIFIVE_INSIGHT_TLA_STATS_EN defined: put_count and get_count are implemented as described.
- SIFIVE_INSIGHT_TLA_STATS_EN undefined: no counter flops exist, and put_count and get_count are constant 0. All other behaviour is identical.

## Test plan
- Get, size=2, addr 0x8000_0000, mask F, source 0, then d_done source 0 → req_done pulses once; outstanding goes 01→00; err_any stays 0; get_count=1.
- PutFull, size=4, 4 beats with a_ready toggling → in_burst is high for beats 1–3; beat_idx steps 1,2,3,0; one req_done; put_count=1.
- Burst whose 3rd beat address changes by 0x4 → err_sticky=0x20 and err_first=5 one cycle later; the burst still ends after beat 4.
- a_valid high with a_ready low, then a_data changes next cycle → err_sticky[6] is set and err_first=6.
- Second Get on source 1 while source 1 is outstanding → err_sticky[7] is set. Then d_done on source 1 plus a new Get on source 1 in the same cycle → no further error, and outstanding[1] stays 1.
- Reset pulsed at beat 2 of a 16-beat Put → all outputs are 0; the next PutFull size=2 is accepted with no error. With stats enabled and 0xFFFF Gets issued → get_count holds at 0xFFFF.

Source files
------------

// File: rtl/sifive_insight_tla_checker.sv
// sifive_insight_tla_checker
// Passive TileLink-UL A-channel checker for the hart-0 data port. It observes
// the A handshake and payload together with D completions. It tracks Put burst
// beats and per-source in-flight state, and latches sticky protocol error flags.
// Optional request statistics are enabled with `define SIFIVE_INSIGHT_TLA_STATS_EN.
module sifive_insight_tla_checker #(
    parameter int MAX_SIZE = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_ready,
    input  logic             a_valid,
    input  logic [2:0]       a_opcode,
    input  logic [2:0]       a_param,
    input  logic [3:0]       a_size,
    input  logic             a_source,
    input  logic [31:0]      a_address,
    input  logic [3:0]       a_mask,
    input  logic [31:0]      a_data,
    input  logic             a_corrupt,
    input  logic             d_done,
    input  logic             d_source,
    input  logic             err_clear,
    output logic [7:0]       err_sticky,
    output logic [2:0]       err_first,
    output logic             err_any,
    output logic [3:0]       beat_idx,
    output logic             in_burst,
    output logic [1:0]       outstanding,
    output logic             req_done,
    output logic [CNT_W-1:0] put_count,
    output logic [CNT_W-1:0] get_count
);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [3:0] MAX_SZ      = 4'(MAX_SIZE);
    localparam int         PAY_W       = 80;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    // Beats minus one. Oversized Puts are clamped so tracking stays bounded.
    function automatic logic [3:0] beats_m1(input logic [2:0] op, input logic [3:0] sz);
        logic [3:0]  s;
        logic [15:0] b;
        b = '0;
        s = (sz > MAX_SZ) ? MAX_SZ : sz;
        if ((op == OP_PUT_FULL || op == OP_PUT_PART) && s > 4'd2)
            b = (16'd1 << (s - 4'd2)) - 16'd1;
        return b[3:0];
    endfunction

    // Byte lanes a request of this size and offset may touch.
    function automatic logic [3:0] lane_mask(input logic [3:0] sz, input logic [1:0] off);
        logic [3:0] m;
        if (sz >= 4'd2)      m = 4'hF;
        else if (sz == 4'd1) m = off[1] ? 4'b1100 : 4'b0011;
        else                 m = 4'b0001 << off;
        return m;
    endfunction

    // Index of the lowest set error bit.
    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction

    state_t          state_q;
    logic [3:0]      beat_idx_q;
    logic            in_burst_q;
    logic [3:0]      last_q;
    logic [2:0]      cap_opcode_q;
    logic [2:0]      cap_param_q;
    logic [3:0]      cap_size_q;
    logic            cap_source_q;
    logic [31:0]     cap_address_q;
    logic            stall_q;
    logic [PAY_W-1:0] pay_q;
    logic [1:0]      outstanding_q, outstanding_d, os_cleared;
    logic [7:0]      err_sticky_q, err_sticky_d, err_base;
    logic [2:0]      err_first_q, err_first_d;
    logic            err_any_q;
    logic            req_done_q;
    logic [7:0]      err_new;

    logic            fire, first_fire, burst_start, burst_last, req_fire, legal_op;
    logic [3:0]      last_m1, exp_mask;
    logic [31:0]     align_mask;
    logic [PAY_W-1:0] pay_now;

    assign fire        = a_valid & a_ready;
    assign first_fire  = fire & (state_q == S_IDLE);
    assign last_m1     = beats_m1(a_opcode, a_size);
    assign burst_start = first_fire & (last_m1 != 4'd0);
    assign burst_last  = fire & (state_q == S_BURST) & (beat_idx_q == last_q);
    assign req_fire    = (first_fire & (last_m1 == 4'd0)) | burst_last;
    assign legal_op    = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PART) | (a_opcode == OP_GET);
    assign exp_mask    = lane_mask(a_size, a_address[1:0]);
    assign pay_now     = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt};

    // Bursts need natural alignment; single beats need alignment to min(2^size, 4).
    always_comb begin
        align_mask = 32'd0;
        if (burst_start)          align_mask = (32'd1 << a_size) - 32'd1;
        else if (a_size >= 4'd2)  align_mask = 32'd3;
        else if (a_size == 4'd1)  align_mask = 32'd1;
    end

    // A same-cycle completion clears before a new first beat sets.
    always_comb begin
        os_cleared = outstanding_q;
        if (d_done) os_cleared[d_source] = 1'b0;
        outstanding_d = os_cleared;
        if (first_fire) outstanding_d[a_source] = 1'b1;
    end

    // Error classes raised by this cycle's activity.
    always_comb begin
        err_new = '0;
        if (fire) begin
            err_new[0] = ~legal_op;
            err_new[1] = (a_param != 3'd0);
            err_new[2] = (a_size > MAX_SZ);
            if (state_q == S_IDLE)
                err_new[3] = ((a_address & align_mask) != 32'd0);
            if (legal_op) begin
                if (a_opcode == OP_PUT_PART) err_new[4] = ((a_mask & ~exp_mask) != 4'd0);
                else                         err_new[4] = (a_mask != exp_mask);
            end
            if (state_q == S_BURST)
                err_new[5] = ({a_opcode, a_param, a_size, a_source, a_address} !=
                              {cap_opcode_q, cap_param_q, cap_size_q, cap_source_q, cap_address_q});
        end
        err_new[6] = stall_q & (~a_valid | (pay_now != pay_q));
        err_new[7] = (first_fire & os_cleared[a_source]) | (d_done & ~outstanding_q[d_source]);
    end

    // Clear empties the sticky state first, and new errors are then OR-ed in.
    always_comb begin
        err_base     = err_clear ? 8'd0 : err_sticky_q;
        err_sticky_d = err_base | err_new;
        err_first_d  = err_clear ? 3'd0 : err_first_q;
        if (err_base == 8'd0 && err_new != 8'd0)
            err_first_d = lowest_bit(err_new);
    end

    // Burst tracking FSM: IDLE until a multi-beat Put starts, BURST until its last beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_idx_q <= 4'd0;
            in_burst_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (burst_start) begin
                        state_q    <= S_BURST;
                        beat_idx_q <= 4'd1;
                        in_burst_q <= 1'b1;
                    end
                end
                default: begin
                    if (fire) begin
                        if (beat_idx_q == last_q) begin
                            state_q    <= S_IDLE;
                            beat_idx_q <= 4'd0;
                            in_burst_q <= 1'b0;
                        end else begin
                            beat_idx_q <= beat_idx_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    // First-beat fields held for the comparison against later beats.
    always_ff @(posedge clock) begin
        if (burst_start) begin
            cap_opcode_q  <= a_opcode;
            cap_param_q   <= a_param;
            cap_size_q    <= a_size;
            cap_source_q  <= a_source;
            cap_address_q <= a_address;
            last_q        <= last_m1;
        end
    end

    // Previous-cycle payload, used to detect changes while the channel is stalled.
    always_ff @(posedge clock) begin
        pay_q <= pay_now;
    end

    // Control state: stall flag, in-flight sources, error flags and the done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q       <= 1'b0;
            outstanding_q <= 2'b00;
            err_sticky_q  <= 8'd0;
            err_first_q   <= 3'd0;
            err_any_q     <= 1'b0;
            req_done_q    <= 1'b0;
        end else begin
            stall_q       <= a_valid & ~a_ready;
            outstanding_q <= outstanding_d;
            err_sticky_q  <= err_sticky_d;
            err_first_q   <= err_first_d;
            err_any_q     <= |err_sticky_d;
            req_done_q    <= req_fire;
        end
    end

`ifdef SIFIVE_INSIGHT_TLA_STATS_EN
    logic [CNT_W-1:0] put_count_q, get_count_q;
    logic             req_is_put, req_is_get;

    // Bursts are always Puts; single beats are classified by their own opcode.
    assign req_is_put = burst_last |
                        (req_fire & ((a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PART)));
    assign req_is_get = req_fire & ~burst_last & (a_opcode == OP_GET);

    // Saturating request counters, updated alongside req_done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            put_count_q <= '0;
            get_count_q <= '0;
        end else begin
            if (req_is_put && put_count_q != '1) put_count_q <= put_count_q + CNT_W'(1);
            if (req_is_get && get_count_q != '1) get_count_q <= get_count_q + CNT_W'(1);
        end
    end

    assign put_count = put_count_q;
    assign get_count = get_count_q;
`else
    assign put_count = '0;
    assign get_count = '0;
`endif

    assign err_sticky  = err_sticky_q;
    assign err_first   = err_first_q;
    assign err_any     = err_any_q;
    assign beat_idx    = beat_idx_q;
    assign in_burst    = in_burst_q;
    assign outstanding = outstanding_q;
    assign req_done    = req_done_q;

endmodule

// File: tb/tb_sifive_insight_tla_checker.sv
// Scoreboard bench for sifive_insight_tla_checker.
module tb_sifive_insight_tla_checker;

`ifdef SIFIVE_INSIGHT_TLA_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [2:0] PF  = 3'd0;
    localparam logic [2:0] PP  = 3'd1;
    localparam logic [2:0] GET = 3'd4;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready, a_valid, a_source, a_corrupt;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size, a_mask;
    logic [31:0] a_address, a_data;
    logic        d_done, d_source, err_clear;
    logic [7:0]  err_sticky;
    logic [2:0]  err_first;
    logic        err_any, in_burst, req_done;
    logic [3:0]  beat_idx;
    logic [1:0]  outstanding;
    logic [15:0] put_count, get_count;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        string      tag;
        logic       rd;
        logic [3:0] bi;
        logic       ib;
        logic [1:0] os;
        logic [7:0] es;
        logic [2:0] ef;
    } exp_t;

    exp_t sb_q[$];

    sifive_insight_tla_checker #(.MAX_SIZE(6), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .a_ready(a_ready), .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .a_corrupt(a_corrupt),
        .d_done(d_done), .d_source(d_source), .err_clear(err_clear),
        .err_sticky(err_sticky), .err_first(err_first), .err_any(err_any),
        .beat_idx(beat_idx), .in_burst(in_burst), .outstanding(outstanding),
        .req_done(req_done), .put_count(put_count), .get_count(get_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic r, input logic [2:0] op, input logic [3:0] sz,
                         input logic src, input logic [31:0] addr, input logic [3:0] m,
                         input logic [31:0] dat);
        a_valid = v; a_ready = r; a_opcode = op; a_param = 3'd0; a_size = sz;
        a_source = src; a_address = addr; a_mask = m; a_data = dat; a_corrupt = 1'b0;
    endtask

    // Expectation is queued with the stimulus and retired after the edge that consumes it.
    task automatic tick(input string tag, input logic rd, input logic [3:0] bi, input logic ib,
                        input logic [1:0] os, input logic [7:0] es, input logic [2:0] ef);
        exp_t e;
        e.tag = tag; e.rd = rd; e.bi = bi; e.ib = ib; e.os = os; e.es = es; e.ef = ef;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check_val({e.tag, ".req_done"},    32'(req_done),    32'(e.rd));
        check_val({e.tag, ".beat_idx"},    32'(beat_idx),    32'(e.bi));
        check_val({e.tag, ".in_burst"},    32'(in_burst),    32'(e.ib));
        check_val({e.tag, ".outstanding"}, 32'(outstanding), 32'(e.os));
        check_val({e.tag, ".err_sticky"},  32'(err_sticky),  32'(e.es));
        check_val({e.tag, ".err_first"},   32'(err_first),   32'(e.ef));
        check_val({e.tag, ".err_any"},     32'(err_any),     32'(e.es != 8'd0));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".err_sticky"},  32'(err_sticky),  0);
        check_val({tag, ".err_first"},   32'(err_first),   0);
        check_val({tag, ".err_any"},     32'(err_any),     0);
        check_val({tag, ".beat_idx"},    32'(beat_idx),    0);
        check_val({tag, ".in_burst"},    32'(in_burst),    0);
        check_val({tag, ".outstanding"}, 32'(outstanding), 0);
        check_val({tag, ".req_done"},    32'(req_done),    0);
        check_val({tag, ".put_count"},   32'(put_count),   0);
        check_val({tag, ".get_count"},   32'(get_count),   0);
    endtask

    initial begin
        reset = 1'b1;
        set_a(0, 0, 3'd0, 4'd0, 0, 32'd0, 4'd0, 32'd0);
        d_done = 1'b0; d_source = 1'b0; err_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        tick("idle", 0, 0, 0, 2'b00, 8'h00, 0);

        // Single Get with its completion
        set_a(1, 1, GET, 4'd2, 0, 32'h8000_0000, 4'hF, 32'h1);
        tick("t1_get", 1, 0, 0, 2'b01, 8'h00, 0);
        a_valid = 0; d_done = 1; d_source = 0;
        tick("t1_d", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0;
        check_val("t1_get_count", 32'(get_count), STATS ? 1 : 0);

        // Four-beat PutFull with back-pressure
        set_a(1, 1, PF, 4'd4, 0, 32'h10, 4'hF, 32'hA0);
        tick("t2_b1", 0, 1, 1, 2'b01, 8'h00, 0);
        a_ready = 0;
        tick("t2_st1", 0, 1, 1, 2'b01, 8'h00, 0);
        a_ready = 1;
        tick("t2_b2", 0, 2, 1, 2'b01, 8'h00, 0);
        a_data = 32'hA2;
        tick("t2_b3", 0, 3, 1, 2'b01, 8'h00, 0);
        a_ready = 0; a_data = 32'hA3;
        tick("t2_st2", 0, 3, 1, 2'b01, 8'h00, 0);
        a_ready = 1;
        tick("t2_b4", 1, 0, 0, 2'b01, 8'h00, 0);
        a_valid = 0; d_done = 1; d_source = 0;
        tick("t2_d", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0;
        check_val("t2_put_count", 32'(put_count), STATS ? 1 : 0);

        // Burst with address change on beat 3
        set_a(1, 1, PF, 4'd4, 1, 32'h20, 4'hF, 32'hB0);
        tick("t3_b1", 0, 1, 1, 2'b10, 8'h00, 0);
        tick("t3_b2", 0, 2, 1, 2'b10, 8'h00, 0);
        a_address = 32'h24;
        tick("t3_b3", 0, 3, 1, 2'b10, 8'h20, 5);
        a_address = 32'h20;
        tick("t3_b4", 1, 0, 0, 2'b10, 8'h20, 5);
        a_valid = 0; d_done = 1; d_source = 1; err_clear = 1;
        tick("t3_clr", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0; err_clear = 0;

        // Payload change while stalled
        set_a(1, 0, GET, 4'd2, 0, 32'h100, 4'hF, 32'hC0);
        tick("t4_st", 0, 0, 0, 2'b00, 8'h00, 0);
        a_data = 32'hC1;
        tick("t4_chg", 0, 0, 0, 2'b00, 8'h40, 6);
        a_ready = 1;
        tick("t4_fire", 1, 0, 0, 2'b01, 8'h40, 6);
        a_valid = 0; d_done = 1; d_source = 0; err_clear = 1;
        tick("t4_clr", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0; err_clear = 0;

        // In-flight source reuse and same-cycle completion
        set_a(1, 1, GET, 4'd2, 1, 32'h200, 4'hF, 32'h0);
        tick("t5_g1", 1, 0, 0, 2'b10, 8'h00, 0);
        tick("t5_g2", 1, 0, 0, 2'b10, 8'h80, 7);
        a_valid = 0; err_clear = 1;
        tick("t5_clr", 0, 0, 0, 2'b10, 8'h00, 0);
        err_clear = 0; a_valid = 1; d_done = 1; d_source = 1;
        tick("t5_dg", 1, 0, 0, 2'b10, 8'h00, 0);
        a_valid = 0;
        tick("t5_d", 0, 0, 0, 2'b00, 8'h00, 0);
        tick("t5_dbad", 0, 0, 0, 2'b00, 8'h80, 7);
        d_done = 0; err_clear = 1;
        tick("t5_clr2", 0, 0, 0, 2'b00, 8'h00, 0);
        err_clear = 0;

        // Size, opcode, mask and alignment boundaries
        set_a(1, 1, GET, 4'd7, 0, 32'h0, 4'hF, 32'h0);
        tick("t6_size", 1, 0, 0, 2'b01, 8'h04, 2);
        a_valid = 0; d_done = 1; d_source = 0; err_clear = 1;
        tick("t6_clr1", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0; err_clear = 0;
        set_a(1, 1, 3'd2, 4'd2, 0, 32'h0, 4'hF, 32'h0);
        tick("t6_op", 1, 0, 0, 2'b01, 8'h01, 0);
        a_valid = 0; d_done = 1; d_source = 0; err_clear = 1;
        tick("t6_clr2", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0; err_clear = 0;
        set_a(1, 1, PP, 4'd0, 0, 32'h3, 4'b1000, 32'h0);
        tick("t6_pp_ok", 1, 0, 0, 2'b01, 8'h00, 0);
        a_mask = 4'b0100; d_done = 1; d_source = 0;
        tick("t6_pp_bad", 1, 0, 0, 2'b01, 8'h10, 4);
        set_a(1, 1, GET, 4'd2, 0, 32'h2, 4'hF, 32'h0);
        err_clear = 1;
        tick("t6_align", 1, 0, 0, 2'b01, 8'h08, 3);
        a_valid = 0;
        tick("t6_clr3", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0; err_clear = 0;
        check_val("t6_get_count", 32'(get_count), STATS ? 7 : 0);
        check_val("t6_put_count", 32'(put_count), STATS ? 4 : 0);

        // Reset in the middle of a 16-beat Put
        set_a(1, 1, PF, 4'd6, 0, 32'h40, 4'hF, 32'h0);
        tick("t7_b1", 0, 1, 1, 2'b01, 8'h00, 0);
        tick("t7_b2", 0, 2, 1, 2'b01, 8'h00, 0);
        reset = 1; a_valid = 0;
        #2;
        check_all_zero("t7_rst");
        @(posedge clock);
        #1;
        reset = 0;
        set_a(1, 1, PF, 4'd2, 0, 32'h4, 4'hF, 32'h0);
        tick("t7_put", 1, 0, 0, 2'b01, 8'h00, 0);
        a_valid = 0; d_done = 1; d_source = 0;
        tick("t7_d", 0, 0, 0, 2'b00, 8'h00, 0);
        d_done = 0;
        check_val("t7_put_count", 32'(put_count), STATS ? 1 : 0);

`ifdef SIFIVE_INSIGHT_TLA_STATS_EN
        // Saturation of the Get counter
        set_a(1, 1, GET, 4'd2, 0, 32'h0, 4'hF, 32'h0);
        @(posedge clock);
        #1;
        d_done = 1; d_source = 0;
        repeat (65540) @(posedge clock);
        #1;
        a_valid = 0;
        @(posedge clock);
        #1;
        d_done = 0;
        check_val("t8_get_sat", 32'(get_count), 32'hFFFF);
        check_val("t8_err_any", 32'(err_any), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
